dbus_arb: RTL and testbench
===========================

DBUS_ARB -- requirements
Module: dbus_arb

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning the address width of requester and memory ports.
REQ-002 The block SHALL have parameter FIXED_PRI, default 0; 0 selects round-robin, 1 means port 0 always wins contention.
REQ-003 The block SHALL use clock clk and reset rstb; rstb is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rstb  input  1  asynchronous active-low reset.
REQ-006 mN_addr  input  AW  byte address from requester N (N=0,1; port 0 = core data port, port 1 = loader/debug).
REQ-007 mN_rd_req / mN_wr_req  input  1 each  read/write request, held high until the matching ready.
REQ-008 mN_be  input  4  write byte enables.
REQ-009 mN_wr_data  input  32  write data.
REQ-010 mN_rd_ready / mN_wr_ready  output  1 each  single-cycle completion pulse.
REQ-011 mN_rd_data  output  32  read data, valid only while mN_rd_ready=1.
REQ-012 mem_cs, mem_we  output  1 each  single-port SRAM select and write enable.
REQ-013 mem_addr  output  AW-2  word address, equal to granted addr[AW-1:2].
REQ-014 mem_be  output  4  byte enables, 4'hF on reads.
REQ-015 mem_wdata  output  32  write data.
REQ-016 mem_rdata  input  32  SRAM read data, valid one cycle after a read strobe.

Function
REQ-017 FSM states SHALL be IDLE and RD_DATA.
REQ-018 Active request SHALL mean rd_req|wr_req; if both are high on one port, the write SHALL be served and the read left pending.
REQ-019 In IDLE with exactly one port active, that port SHALL be granted in the same cycle, combinationally.
REQ-020 In IDLE with both ports active, FIXED_PRI=0 SHALL grant the port not recorded in last_grant; FIXED_PRI=1 SHALL grant port 0.
REQ-021 last_grant SHALL update on every grant.
REQ-022 Granted write: in the grant cycle the block SHALL drive mem_cs=1 and mem_we=1 and pass addr/be/data, pulse that port's wr_ready, and stay in IDLE (zero-wait write).
REQ-023 Granted read: in the grant cycle the block SHALL drive mem_cs=1, mem_we=0 and mem_be=4'hF, latch the grant into a register, and go to RD_DATA.
REQ-024 In RD_DATA the block SHALL pulse rd_ready of the latched port, drive its rd_data=mem_rdata, assert no mem_cs, and return to IDLE (read latency 1 cycle; 1 bubble before the next grant).
REQ-025 mN_rd_data SHALL be 0 whenever mN_rd_ready=0.
REQ-026 The non-granted port SHALL see no ready pulse and remain pending, with no request lost.
REQ-027 At most one mem access SHALL occur per cycle, and ready SHALL never be pulsed to both ports in the same cycle.
REQ-028 A request dropped before grant SHALL be ignored; a request dropped during RD_DATA SHALL still complete the read into SRAM, and the rd_ready pulse SHALL be suppressed.
REQ-029 With no active port in IDLE, all mem outputs SHALL be 0.

Reset
REQ-030 While rstb=0: state=IDLE, last_grant=1 (port 0 wins the first tie), latched grant=0, all outputs 0.
REQ-031 Reset asserted in RD_DATA SHALL abort the read with no rd_ready pulse; after release the block starts in IDLE.

Verification
REQ-032 m0 write addr=0x100 be=4'h3 data=0xAABBCCDD -> same cycle: mem_cs=1, mem_we=1, mem_addr=0x40, mem_be=3, m0_wr_ready=1.
REQ-033 m1 read addr=0x8 with SRAM word2=0x12345678 -> cycle0 mem_cs=1, mem_addr=2; cycle1 m1_rd_ready=1, m1_rd_data=0x12345678.
REQ-034 Both ports write continuously, FIXED_PRI=0, from reset -> grants alternate 0,1,0,1 each cycle.
REQ-035 Both ports write continuously, FIXED_PRI=1 -> port 0 granted every cycle; port 1 never granted until m0 drops its request.
REQ-036 m0 read granted, then rstb=0 in the RD_DATA cycle -> no m0_rd_ready; all outputs 0; after release an idle bus shows mem_cs=0.
REQ-037 m0 and m1 both read in the same cycle -> m0 done at cycle1, m1 granted cycle2, m1_rd_ready at cycle3.

Source files
------------

// File: rtl/dbus_arb.sv
// Two-requester arbiter in front of a single-port SRAM.
// Port 0 is the core data port, port 1 the loader/debug port. Writes complete
// in the grant cycle; reads take one extra cycle for the SRAM data to return.
module dbus_arb #(
    parameter int AW        = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_rd_req,
    input  logic          m0_wr_req,
    input  logic [3:0]    m0_be,
    input  logic [31:0]   m0_wr_data,
    output logic          m0_rd_ready,
    output logic          m0_wr_ready,
    output logic [31:0]   m0_rd_data,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_rd_req,
    input  logic          m1_wr_req,
    input  logic [3:0]    m1_be,
    input  logic [31:0]   m1_wr_data,
    output logic          m1_rd_ready,
    output logic          m1_wr_ready,
    output logic [31:0]   m1_rd_data,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic {IDLE, RD_DATA} state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   rd_port_q, rd_port_d;

    logic [1:0]    rd_req;
    logic [1:0]    wr_req;
    logic [1:0]    active;
    logic [1:0]    rd_ready;
    logic [1:0]    wr_ready;
    logic          grant;
    logic [AW-1:0] grant_addr;
    logic [3:0]    grant_be;
    logic [31:0]   grant_wdata;
    logic [31:0]   rd_data [2];

    // Byte offset bits are not used by a word-addressed SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

    assign rd_req = {m1_rd_req, m0_rd_req};
    assign wr_req = {m1_wr_req, m0_wr_req};
    assign active = rd_req | wr_req;

    // Winner among active ports: on contention either alternate or favour port 0.
    always_comb begin
        grant = active[1];
        if (active == 2'b11) begin
            grant = (FIXED_PRI != 0) ? 1'b0 : ~last_grant_q;
        end
    end

    assign grant_addr  = grant ? m1_addr    : m0_addr;
    assign grant_be    = grant ? m1_be      : m0_be;
    assign grant_wdata = grant ? m1_wr_data : m0_wr_data;

    // Next state and all bus/handshake outputs; everything is held at 0 during reset.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rd_port_d    = rd_port_q;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_be       = 4'h0;
        mem_wdata    = 32'h0;
        rd_ready     = 2'b00;
        wr_ready     = 2'b00;
        if (rstb) begin
            case (state_q)
                IDLE: begin
                    if (|active) begin
                        last_grant_d = grant;
                        mem_cs       = 1'b1;
                        mem_addr     = grant_addr[AW-1:2];
                        if (wr_req[grant]) begin
                            // A write wins over a simultaneous read on the same port.
                            mem_we          = 1'b1;
                            mem_be          = grant_be;
                            mem_wdata       = grant_wdata;
                            wr_ready[grant] = 1'b1;
                        end else begin
                            mem_be    = 4'hF;
                            rd_port_d = grant;
                            state_d   = RD_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    // A requester that gave up while the SRAM was busy gets no pulse.
                    rd_ready[rd_port_q] = rd_req[rd_port_q];
                    state_d             = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read data is forced to zero outside the completion pulse.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_data
            assign rd_data[gi] = rd_ready[gi] ? mem_rdata : 32'h0;
        end
    endgenerate

    assign m0_rd_ready = rd_ready[0];
    assign m1_rd_ready = rd_ready[1];
    assign m0_wr_ready = wr_ready[0];
    assign m1_wr_ready = wr_ready[1];
    assign m0_rd_data  = rd_data[0];
    assign m1_rd_data  = rd_data[1];

    // State registers; last_grant resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            rd_port_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rd_port_q    <= rd_port_d;
        end
    end

endmodule

// File: tb/tb_dbus_arb.sv
// Bench for dbus_arb: one round-robin and one fixed-priority instance, each
// behind its own SRAM, checked every cycle against a transaction-level model.
module tb_dbus_arb;
    localparam int AW = 32;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    // [instance][port]
    logic          rd_req_s  [2][2];
    logic          wr_req_s  [2][2];
    logic [AW-1:0] addr_s    [2][2];
    logic [3:0]    be_s      [2][2];
    logic [31:0]   wdata_s   [2][2];
    logic          rd_rdy_w  [2][2];
    logic          wr_rdy_w  [2][2];
    logic [31:0]   rd_data_w [2][2];
    logic          mem_cs_w    [2];
    logic          mem_we_w    [2];
    logic [AW-3:0] mem_addr_w  [2];
    logic [3:0]    mem_be_w    [2];
    logic [31:0]   mem_wdata_w [2];
    logic [31:0]   mem_rdata_s [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        dbus_arb #(.AW(AW), .FIXED_PRI(gi)) u_dut (
            .clk(clk), .rstb(rstb),
            .m0_addr(addr_s[gi][0]), .m0_rd_req(rd_req_s[gi][0]), .m0_wr_req(wr_req_s[gi][0]),
            .m0_be(be_s[gi][0]), .m0_wr_data(wdata_s[gi][0]),
            .m0_rd_ready(rd_rdy_w[gi][0]), .m0_wr_ready(wr_rdy_w[gi][0]), .m0_rd_data(rd_data_w[gi][0]),
            .m1_addr(addr_s[gi][1]), .m1_rd_req(rd_req_s[gi][1]), .m1_wr_req(wr_req_s[gi][1]),
            .m1_be(be_s[gi][1]), .m1_wr_data(wdata_s[gi][1]),
            .m1_rd_ready(rd_rdy_w[gi][1]), .m1_wr_ready(wr_rdy_w[gi][1]), .m1_rd_data(rd_data_w[gi][1]),
            .mem_cs(mem_cs_w[gi]), .mem_we(mem_we_w[gi]), .mem_addr(mem_addr_w[gi]),
            .mem_be(mem_be_w[gi]), .mem_wdata(mem_wdata_w[gi]), .mem_rdata(mem_rdata_s[gi])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // SRAM environment: byte-enabled writes, read data one cycle after the strobe,
    // random junk otherwise so ungated read data shows up.
    logic [31:0] sram [2][16];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_cs_w[k] && mem_we_w[k]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_w[k][b]) sram[k][mem_addr_w[k][3:0]][8*b +: 8] = mem_wdata_w[k][8*b +: 8];
            end
            if (mem_cs_w[k] && !mem_we_w[k]) mem_rdata_s[k] = sram[k][mem_addr_w[k][3:0]];
            else                             mem_rdata_s[k] = $urandom;
        end
    end

    // Reference model: a read in flight or not, who won last, and the memory image.
    logic          m_busy [2];
    logic          m_port [2];
    logic          m_last [2];
    logic [31:0]   m_rdata[2];
    logic [31:0]   ref_mem[2][16];
    logic          e_rr [2][2];
    logic          e_wr [2][2];
    logic [31:0]   e_rd [2];
    logic          e_cs, e_we, chk_full, chk_wd, act0, act1, win, pp;
    logic [AW-3:0] e_addr;
    logic [3:0]    e_be;
    logic [31:0]   e_wd;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_be = 4'h0; e_wd = 32'h0;
            chk_full = 1'b1; chk_wd = 1'b1;
            for (int p = 0; p < 2; p++) begin
                e_rr[k][p] = 1'b0; e_wr[k][p] = 1'b0; e_rd[p] = 32'h0;
            end
            if (!rstb) begin
                m_busy[k] = 1'b0; m_last[k] = 1'b1; m_port[k] = 1'b0;
            end else if (m_busy[k]) begin
                chk_full = 1'b0;
                pp = m_port[k];
                if (rd_req_s[k][pp]) begin
                    e_rr[k][pp] = 1'b1;
                    e_rd[pp]    = m_rdata[k];
                    $display("[TB] i%0d m%0d RD addr=%h data=%h", k, pp, addr_s[k][pp], m_rdata[k]);
                end
                m_busy[k] = 1'b0;
            end else begin
                act0 = rd_req_s[k][0] | wr_req_s[k][0];
                act1 = rd_req_s[k][1] | wr_req_s[k][1];
                if (act0 || act1) begin
                    if (act0 && act1) win = (k == 1) ? 1'b0 : !m_last[k];
                    else              win = act1;
                    m_last[k] = win;
                    e_cs      = 1'b1;
                    e_addr    = addr_s[k][win][AW-1:2];
                    if (wr_req_s[k][win]) begin
                        e_we = 1'b1; e_be = be_s[k][win]; e_wd = wdata_s[k][win];
                        e_wr[k][win] = 1'b1;
                        for (int b = 0; b < 4; b++)
                            if (be_s[k][win][b])
                                ref_mem[k][addr_s[k][win][5:2]][8*b +: 8] = wdata_s[k][win][8*b +: 8];
                        $display("[TB] i%0d m%0d WR addr=%h be=%h data=%h", k, win, addr_s[k][win], be_s[k][win], wdata_s[k][win]);
                    end else begin
                        e_be = 4'hF; chk_wd = 1'b0;
                        m_busy[k] = 1'b1; m_port[k] = win;
                        m_rdata[k] = ref_mem[k][addr_s[k][win][5:2]];
                    end
                end
            end
            check_val($sformatf("i%0d_cs", k), 64'(mem_cs_w[k]), 64'(e_cs));
            if (chk_full) begin
                check_val($sformatf("i%0d_we", k),   64'(mem_we_w[k]),   64'(e_we));
                check_val($sformatf("i%0d_addr", k), 64'(mem_addr_w[k]), 64'(e_addr));
                check_val($sformatf("i%0d_be", k),   64'(mem_be_w[k]),   64'(e_be));
                if (chk_wd) check_val($sformatf("i%0d_wdata", k), 64'(mem_wdata_w[k]), 64'(e_wd));
            end
            for (int p = 0; p < 2; p++) begin
                check_val($sformatf("i%0d_m%0d_rd_ready", k, p), 64'(rd_rdy_w[k][p]),  64'(e_rr[k][p]));
                check_val($sformatf("i%0d_m%0d_wr_ready", k, p), 64'(wr_rdy_w[k][p]),  64'(e_wr[k][p]));
                check_val($sformatf("i%0d_m%0d_rd_data", k, p),  64'(rd_data_w[k][p]), 64'(e_rd[p]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                rd_req_s[k][p] = 1'b0; wr_req_s[k][p] = 1'b0;
            end
    endtask

    task automatic set_req(input int k, input int p, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        rd_req_s[k][p] = rd; wr_req_s[k][p] = wr;
        addr_s[k][p] = a; be_s[k][p] = be; wdata_s[k][p] = d;
    endtask

    logic pend [2][2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            mem_rdata_s[k] = 32'h0;
            for (int w = 0; w < 16; w++) begin
                sram[k][w]    = $urandom;
                ref_mem[k][w] = sram[k][w];
            end
            sram[k][2]    = 32'h12345678;
            ref_mem[k][2] = 32'h12345678;
            for (int p = 0; p < 2; p++) begin
                set_req(k, p, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
                pend[k][p] = 1'b0;
            end
        end

        // Reset state
        @(negedge clk);
        check_val("rst_cs", 64'(mem_cs_w[0]), 64'(0));
        check_val("rst_m0_wr_ready", 64'(wr_rdy_w[0][0]), 64'(0));
        @(posedge clk); #1;
        rstb = 1'b1;

        // Zero-wait write on port 0
        set_req(0, 0, 1'b0, 1'b1, 32'h100, 4'h3, 32'hAABBCCDD);
        @(negedge clk);
        check_val("wr_cs", 64'(mem_cs_w[0]), 64'(1));
        check_val("wr_we", 64'(mem_we_w[0]), 64'(1));
        check_val("wr_addr", 64'(mem_addr_w[0]), 64'(32'h40));
        check_val("wr_be", 64'(mem_be_w[0]), 64'(4'h3));
        check_val("wr_data", 64'(mem_wdata_w[0]), 64'(32'hAABBCCDD));
        check_val("wr_ready", 64'(wr_rdy_w[0][0]), 64'(1));
        tick();
        idle_all();

        // One-cycle read on port 1
        set_req(0, 1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
        @(negedge clk);
        check_val("rd_cs", 64'(mem_cs_w[0]), 64'(1));
        check_val("rd_addr", 64'(mem_addr_w[0]), 64'(2));
        check_val("rd_be", 64'(mem_be_w[0]), 64'(4'hF));
        check_val("rd_early_ready", 64'(rd_rdy_w[0][1]), 64'(0));
        tick();
        @(negedge clk);
        check_val("rd_ready", 64'(rd_rdy_w[0][1]), 64'(1));
        check_val("rd_data", 64'(rd_data_w[0][1]), 64'(32'h12345678));
        check_val("rd_bubble_cs", 64'(mem_cs_w[0]), 64'(0));
        tick();
        idle_all();

        // Continuous writes from both ports, starting from reset
        rstb = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++)
                set_req(k, p, 1'b0, 1'b1, $urandom, 4'($urandom), $urandom);
        tick();
        rstb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val($sformatf("rr_m0_c%0d", i), 64'(wr_rdy_w[0][0]), 64'(i % 2 == 0));
            check_val($sformatf("rr_m1_c%0d", i), 64'(wr_rdy_w[0][1]), 64'(i % 2 == 1));
            check_val($sformatf("fp_m0_c%0d", i), 64'(wr_rdy_w[1][0]), 64'(1));
            check_val($sformatf("fp_m1_c%0d", i), 64'(wr_rdy_w[1][1]), 64'(0));
            tick();
        end
        wr_req_s[0][0] = 1'b0;
        wr_req_s[1][0] = 1'b0;
        @(negedge clk);
        check_val("fp_m1_after_drop", 64'(wr_rdy_w[1][1]), 64'(1));
        tick();
        idle_all();

        // Reset during the read data cycle aborts the read
        set_req(0, 0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
        @(negedge clk);
        check_val("abort_grant_cs", 64'(mem_cs_w[0]), 64'(1));
        tick();
        rstb = 1'b0;
        @(negedge clk);
        check_val("abort_rd_ready", 64'(rd_rdy_w[0][0]), 64'(0));
        check_val("abort_rd_data", 64'(rd_data_w[0][0]), 64'(0));
        check_val("abort_cs", 64'(mem_cs_w[0]), 64'(0));
        tick();
        rstb = 1'b1;
        idle_all();
        @(negedge clk);
        check_val("abort_idle_cs", 64'(mem_cs_w[0]), 64'(0));
        tick();

        // Simultaneous reads: port 0 first, port 1 after the bubble
        set_req(0, 0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        set_req(0, 1, 1'b1, 1'b0, 32'h24, 4'h0, 32'h0);
        @(negedge clk);
        check_val("dual_c0_addr", 64'(mem_addr_w[0]), 64'(8));
        tick();
        @(negedge clk);
        check_val("dual_c1_m0_ready", 64'(rd_rdy_w[0][0]), 64'(1));
        check_val("dual_c1_m1_ready", 64'(rd_rdy_w[0][1]), 64'(0));
        tick();
        rd_req_s[0][0] = 1'b0;
        @(negedge clk);
        check_val("dual_c2_cs", 64'(mem_cs_w[0]), 64'(1));
        check_val("dual_c2_addr", 64'(mem_addr_w[0]), 64'(9));
        tick();
        @(negedge clk);
        check_val("dual_c3_m1_ready", 64'(rd_rdy_w[0][1]), 64'(1));
        tick();
        idle_all();

        // Random traffic: requests held until ready, occasional drops and resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            rstb = ($urandom_range(0, 399) != 0);
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    if (pend[k][p]) begin
                        if (e_wr[k][p]) begin
                            wr_req_s[k][p] = 1'b0;
                            if (!rd_req_s[k][p]) pend[k][p] = 1'b0;
                        end else if (e_rr[k][p]) begin
                            rd_req_s[k][p] = 1'b0;
                            pend[k][p] = 1'b0;
                        end else if ($urandom_range(0, 29) == 0) begin
                            rd_req_s[k][p] = 1'b0;
                            wr_req_s[k][p] = 1'b0;
                            pend[k][p] = 1'b0;
                        end
                    end else if ($urandom_range(0, 2) == 0) begin
                        int r;
                        r = $urandom_range(0, 4);
                        set_req(k, p, (r >= 2), (r < 2) || (r == 4), $urandom, 4'($urandom), $urandom);
                        pend[k][p] = 1'b1;
                    end
                end
        end
        tick();
        rstb = 1'b1;
        idle_all();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
